// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width, reset PC, and instruction field layout.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  typedef enum logic [1:0] {
    OP_DP  = 2'd0,
    OP_MEM = 2'd1,
    OP_BR  = 2'd2,
    OP_RSV = 2'd3
  } op_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; simultaneous push and pop are allowed even when full.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues in-order word reads, buffers two returned
// instructions for decode, and discards stale responses after a redirect.
module instr_fetch #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic [XLEN-1:0] pc_plus8,
  output logic [3:0]      cond,
  output logic [1:0]      op,
  output logic [5:0]      funct,
  output logic [3:0]      rd
);
  import cpu_pkg::*;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [1:0]        outstanding_q, outstanding_d;
  logic [1:0]        drop_cnt_q, drop_cnt_d;
  logic              run_q;
  logic              accept, rsp_seen, rsp_drop, rsp_keep, pop;
  logic [2:0]        slots_used;
  logic [XLEN-1:0]   tag_addr;
  logic [1:0]        tag_count, buf_count;
  logic              tag_full, tag_empty, buf_full, buf_empty;
  logic [2*XLEN-1:0] buf_head;
  logic              unused_ok;

  assign rsp_seen = imem_rsp_valid && (outstanding_q != 2'd0);
  assign rsp_drop = rsp_seen && (drop_cnt_q != 2'd0);
  assign rsp_keep = rsp_seen && (drop_cnt_q == 2'd0) && !tag_empty && !redirect_valid;
  assign pop      = ir_valid && ir_ready && !redirect_valid;

  // A word leaving to decode this cycle frees its slot, which is what lets a
  // 1-cycle memory sustain one instruction per cycle.
  assign slots_used = {1'b0, outstanding_q - drop_cnt_q} + {1'b0, buf_count} - {2'b0, pop};

  assign imem_req_valid = run_q && !redirect_valid && (slots_used < 3'd2)
                          && (outstanding_q != 2'd3) && !tag_full;
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc_q;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, rsp_seen};
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      drop_cnt_d = outstanding_q - {1'b0, rsp_seen};
    end else begin
      if (accept)   pc_d       = pc_q + XLEN'(4);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - 2'd1;
    end
  end

  // run_q keeps the request channel quiet while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      run_q         <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      run_q         <= 1'b1;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(2)) u_tag_q (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (accept),
    .data_i  (pc_q),
    .pop_i   (rsp_keep),
    .flush_i (redirect_valid),
    .data_o  (tag_addr),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(2)) u_ir_buf (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (rsp_keep),
    .data_i  ({imem_rsp_data, tag_addr}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign unused_ok = &{1'b0, tag_count, buf_full};

  assign ir_valid = !buf_empty;
  assign ir       = buf_head[2*XLEN-1:XLEN];
  assign ir_pc    = buf_head[XLEN-1:0];
  assign pc_plus8 = ir_pc + XLEN'(8);
  assign cond     = ir[COND_HI:COND_LO];
  assign op       = ir[OP_HI:OP_LO];
  assign funct    = ir[FUNCT_HI:FUNCT_LO];
  assign rd       = ir[RD_HI:RD_LO];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multicycle-core instruction fetch stage that sits directly upstream of the decoder and control FSM. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers up to two returned instruction words. It presents the oldest buffered word, with its address and pre-sliced decoder fields (`op`, `funct`, `rd`, `cond`), on a valid/ready channel to the decode stage. Branch or PC-write redirects from the FSM flush the buffer and discard in-flight responses.

## Interface
- `XLEN`, 32: data and address width.
- `RESET_PC`, 32'h0: PC value after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `imem_req_valid`  out  1  fetch request present.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  XLEN  word address of the request (equals current PC).
- `imem_rsp_valid`  in  1  read data returned; responses arrive in order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  XLEN  instruction word.
- `redirect_valid`  in  1  new PC from branch or `pcs` write.
- `redirect_pc`  in  XLEN  redirect target, word-aligned.
- `ir_valid`  out  1  buffered instruction available.
- `ir_ready`  in  1  decode stage consumes the instruction.
- `ir`  out  XLEN  head instruction word.
- `ir_pc`  out  XLEN  address of `ir`.
- `pc_plus8`  out  XLEN  `ir_pc + 8` (R15 read value).
- `cond`  out  4  `ir[31:28]`.
- `op`  out  2  `ir[27:26]`.
- `funct`  out  6  `ir[25:20]`.
- `rd`  out  4  `ir[15:12]`.

## Operation
- State: `pc`, `outstanding` (2 bits; accepted requests awaiting response), `drop_cnt` (2 bits; stale responses to discard), and a 2-entry FIFO of {word, addr}.
- Issue rule: `imem_req_valid = !redirect_valid && (outstanding - drop_cnt) + fifo_count < 2 && outstanding < 3`.
- On acceptance (`imem_req_valid && imem_req_ready`): `pc <= pc + 4`, `outstanding` increments, and the address is pushed into an in-order address tag queue. PC wraps modulo 2^XLEN.
- On response: `outstanding` decrements. If `drop_cnt > 0`, the response is discarded and `drop_cnt` decrements. Otherwise {data, tagged addr} is pushed into the FIFO.
- Pop: on `ir_valid && ir_ready`. Push and pop may occur in the same cycle when the FIFO is full; the count is unchanged.
- Redirect: `pc <= redirect_pc` and the FIFO is emptied. Any response in the same cycle is discarded. `drop_cnt <= outstanding - imem_rsp_valid`. `redirect_valid` has priority over pop, push, and issue. An unaccepted request may be withdrawn in the redirect cycle; memory must tolerate this.
- Consecutive redirects: the last one wins. `drop_cnt` is recomputed each time.
- Field outputs are pure slices of `ir`. `pc_plus8` is combinational from `ir_pc`.

## Timing
- Reset (async assert, sync release): `pc = RESET_PC`; all counters are 0; FIFO is empty; `imem_req_valid = 0`, `ir_valid = 0`; `ir`, `ir_pc`, and fields are 0; `pc_plus8 = 8`.
- First request is valid in the first cycle after reset release.
- Response at cycle n produces `ir_valid` at n+1 (FIFO is registered). With 1-cycle memory and `ir_ready = 1`, steady-state throughput is 1 instruction per cycle.
- Redirect at cycle t: request for `redirect_pc` is valid at t+1. `ir_valid = 0` from t+1 until the first fresh response is registered.
- Reset asserted mid-transaction: all state clears immediately. Memory responses after reset are not tracked; memory must be reset together with this block.
- While `imem_req_valid && !imem_req_ready` and no redirect occurs, `imem_addr` holds stable.

## Structure
- `cpu_pkg`: `XLEN`, instruction field bit positions (`COND_HI/LO`, `OP_HI/LO`, `FUNCT_HI/LO`, `RD_HI/LO`), op encodings (`OP_DP = 2'd0`, `OP_MEM = 2'd1`, `OP_BR = 2'd2`), and `RESET_PC` default.
- Sub-module `fetch_fifo`: parameterised width and depth (2), with push, pop, flush, count, full, and empty. It is instantiated twice: once for the address tag queue and once for the {word, addr} buffer.

## Test plan
- Reset then 1-cycle memory with `ir_ready = 1`: requests 0x0, 0x4, 0x8, …, one per cycle. `ir_pc` sequence is 0, 4, 8, … and `pc_plus8` is 8, 12, 16, ….
- `ir_ready = 0` held: exactly 2 requests are accepted, `imem_req_valid` drops, and the FIFO holds the words from 0x0 and 0x4. Raising `ir_ready` resumes issue with 0x8.
- Redirect to 0x100 with 2 responses outstanding (3-cycle latency): both stale words are discarded, and the next `ir_pc` is 0x100 with its word.
- Redirect coincident with a response and a pop: the response is dropped, the FIFO is empty, the next request goes to `redirect_pc`, and `drop_cnt = outstanding - 1`.
- `imem_req_ready` low for 5 cycles: `imem_addr` is stable, and `pc` advances only on acceptance.
- `reset` asserted mid-stream with FIFO full: on the same edge `ir_valid = 0` and `imem_req_valid = 0`. After release the request address is `RESET_PC`.
